// File: rtl/fast_sched_pkg.sv
// rtl/fast_sched_pkg.sv - state encoding and default widths for the fast_ip frame scheduler
package fast_sched_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    RUN   = 3'd2,
    DONE  = 3'd3,
    ERROR = 3'd4
  } state_t;

  localparam int DEF_W_DIM      = 12;
  localparam int DEF_W_CNT      = 16;
  localparam int DEF_WDOG_W     = 20;
  localparam int DEF_WDOG_LIMIT = 1000000;
  // Smallest frame the 7x7 FAST window can process.
  localparam int DEF_MIN_DIM    = 7;

endpackage

// File: rtl/fast_stall_watchdog.sv
// rtl/fast_stall_watchdog.sv - consecutive-stall counter that flags a hung kernel
module fast_stall_watchdog #(
  parameter int WDOG_W     = 20,
  parameter int WDOG_LIMIT = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic stall,
  input  logic kick,
  output logic expired
);

  localparam logic [WDOG_W-1:0] LAST = WDOG_W'(WDOG_LIMIT - 1);

  logic [WDOG_W-1:0] cnt;

  // Expiry needs a stalled cycle on top of LIMIT-1 counted ones; a kick in the same cycle wins.
  assign expired = en && stall && !kick && (cnt == LAST);

  // Count consecutive stalled cycles; any progress, completion or leaving the active states restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || kick || !stall) begin
      cnt <= '0;
    end else if (cnt != LAST) begin
      cnt <= cnt + WDOG_W'(1);
    end
  end

endmodule

// File: rtl/fast_frame_scheduler.sv
// rtl/fast_frame_scheduler.sv - sequences fast_ip (ap_ctrl_hs) over a programmed run of frames
module fast_frame_scheduler
  import fast_sched_pkg::*;
#(
  parameter int W_DIM      = DEF_W_DIM,
  parameter int W_CNT      = DEF_W_CNT,
  parameter int WDOG_W     = DEF_WDOG_W,
  parameter int WDOG_LIMIT = DEF_WDOG_LIMIT,
  parameter int MIN_DIM    = DEF_MIN_DIM
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [W_DIM-1:0] cfg_width,
  input  logic [W_DIM-1:0] cfg_height,
  input  logic [7:0]       cfg_threshold,
  input  logic [W_CNT-1:0] cfg_num_frames,
  input  logic             ctrl_abort,
  input  logic             ctrl_clear,
  output logic             k_ap_start,
  input  logic             k_ap_ready,
  input  logic             k_ap_done,
  input  logic             k_ap_idle,
  output logic [W_DIM-1:0] k_width,
  output logic [W_DIM-1:0] k_height,
  output logic [7:0]       k_threshold,
  input  logic             src_blk,
  input  logic             dst_blk,
  output logic             busy,
  output logic [W_CNT-1:0] frames_done,
  output logic             irq_done,
  output logic             err_cfg,
  output logic             err_stall
);

  localparam logic [W_DIM-1:0] MIN_V = W_DIM'(MIN_DIM);

  state_t           state, state_nxt;
  logic [W_CNT-1:0] num_frames;
  logic             abort_pending;
  logic             dims_ok;
  logic             accept;
  logic             frame_done;
  logic             last_frame;
  logic             active;
  logic             expired;

  assign dims_ok = (cfg_width >= MIN_V) && (cfg_height >= MIN_V);
  assign accept  = (state == IDLE) && cfg_valid && dims_ok;
  assign active  = (state == START) || (state == RUN);

  // A done coinciding with the start handshake counts as a completed frame straight away.
  assign frame_done = ((state == START) && k_ap_ready && k_ap_done) ||
                      ((state == RUN) && k_ap_done);

  // Zero frames means continuous, so the terminal compare is masked; an abort arriving with done still counts.
  assign last_frame = ((num_frames != '0) && (frames_done + W_CNT'(1) == num_frames)) ||
                      abort_pending || ctrl_abort;

  fast_stall_watchdog #(
    .WDOG_W     (WDOG_W),
    .WDOG_LIMIT (WDOG_LIMIT)
  ) u_wdog (
    .clk     (ap_clk),
    .rst_n   (ap_rst_n),
    .en      (active),
    .stall   (src_blk | dst_blk),
    .kick    (k_ap_done),
    .expired (expired)
  );

  // State register; reset drops k_ap_start immediately since it decodes straight from state.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and control outputs.
  always_comb begin
    state_nxt  = state;
    k_ap_start = 1'b0;
    busy       = 1'b1;
    irq_done   = 1'b0;
    cfg_ready  = 1'b0;
    case (state)
      IDLE: begin
        busy      = 1'b0;
        cfg_ready = cfg_valid;
        if (accept) begin
          state_nxt = START;
        end
      end
      START: begin
        k_ap_start = 1'b1;
        if (expired) begin
          state_nxt = ERROR;
        end else if (k_ap_ready) begin
          if (k_ap_done) begin
            state_nxt = last_frame ? DONE : START;
          end else begin
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        if (expired) begin
          state_nxt = ERROR;
        end else if (k_ap_done) begin
          state_nxt = last_frame ? DONE : START;
        end
      end
      DONE: begin
        irq_done  = 1'b1;
        state_nxt = IDLE;
      end
      ERROR: begin
        if (ctrl_clear && k_ap_idle) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Run configuration, frame counter, abort latch and sticky error flags.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      k_width       <= '0;
      k_height      <= '0;
      k_threshold   <= '0;
      num_frames    <= '0;
      frames_done   <= '0;
      abort_pending <= 1'b0;
      err_cfg       <= 1'b0;
      err_stall     <= 1'b0;
    end else begin
      if ((state == IDLE) && cfg_valid && !dims_ok) begin
        err_cfg <= 1'b1;
      end
      if (accept) begin
        k_width       <= cfg_width;
        k_height      <= cfg_height;
        k_threshold   <= cfg_threshold;
        num_frames    <= cfg_num_frames;
        frames_done   <= '0;
        abort_pending <= 1'b0;
      end
      if (active && ctrl_abort) begin
        abort_pending <= 1'b1;
      end
      if (frame_done) begin
        frames_done <= frames_done + W_CNT'(1);
      end
      if (expired) begin
        err_stall <= 1'b1;
      end
      if ((state == ERROR) && ctrl_clear && k_ap_idle) begin
        err_stall <= 1'b0;
        err_cfg   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fast_frame_scheduler.sv
// tb/tb_fast_frame_scheduler.sv - self-checking bench for fast_frame_scheduler
module tb_fast_frame_scheduler;

  localparam int W_DIM = 12;
  localparam int W_CNT = 16;

  logic             ap_clk = 1'b0;
  logic             ap_rst_n;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [W_DIM-1:0] cfg_width;
  logic [W_DIM-1:0] cfg_height;
  logic [7:0]       cfg_threshold;
  logic [W_CNT-1:0] cfg_num_frames;
  logic             ctrl_abort;
  logic             ctrl_clear;
  logic             k_ap_start;
  logic             k_ap_ready;
  logic             k_ap_done;
  logic             k_ap_idle;
  logic [W_DIM-1:0] k_width;
  logic [W_DIM-1:0] k_height;
  logic [7:0]       k_threshold;
  logic             src_blk;
  logic             dst_blk;
  logic             busy;
  logic [W_CNT-1:0] frames_done;
  logic             irq_done;
  logic             err_cfg;
  logic             err_stall;

  logic auto_kernel;
  logic h_ready, h_done, h_idle;
  logic m_ready = 1'b0;
  logic m_done  = 1'b0;
  int   phase   = 0;
  int   wcnt    = 0;
  int   hs_mon  = 0;
  int   irq_cnt = 0;
  int   checks  = 0;
  int   errors  = 0;

  assign k_ap_ready = auto_kernel ? m_ready : h_ready;
  assign k_ap_done  = auto_kernel ? m_done  : h_done;
  assign k_ap_idle  = auto_kernel ? (phase == 0) : h_idle;

  always #5 ap_clk = ~ap_clk;

  fast_frame_scheduler #(
    .WDOG_LIMIT (16)
  ) dut (
    .ap_clk         (ap_clk),
    .ap_rst_n       (ap_rst_n),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .cfg_width      (cfg_width),
    .cfg_height     (cfg_height),
    .cfg_threshold  (cfg_threshold),
    .cfg_num_frames (cfg_num_frames),
    .ctrl_abort     (ctrl_abort),
    .ctrl_clear     (ctrl_clear),
    .k_ap_start     (k_ap_start),
    .k_ap_ready     (k_ap_ready),
    .k_ap_done      (k_ap_done),
    .k_ap_idle      (k_ap_idle),
    .k_width        (k_width),
    .k_height       (k_height),
    .k_threshold    (k_threshold),
    .src_blk        (src_blk),
    .dst_blk        (dst_blk),
    .busy           (busy),
    .frames_done    (frames_done),
    .irq_done       (irq_done),
    .err_cfg        (err_cfg),
    .err_stall      (err_stall)
  );

  // Kernel model: ready 2 cycles after start is seen, done 100 cycles after ready.
  always @(negedge ap_clk) begin
    m_ready = 1'b0;
    m_done  = 1'b0;
    if (!auto_kernel) begin
      phase = 0;
      wcnt  = 0;
    end else if (phase == 0) begin
      if (k_ap_start) begin
        wcnt = wcnt + 1;
        if (wcnt == 2) begin
          m_ready = 1'b1;
          phase   = 1;
          wcnt    = 0;
        end
      end
    end else begin
      wcnt = wcnt + 1;
      if (wcnt == 100) begin
        m_done = 1'b1;
        phase  = 0;
        wcnt   = 0;
      end
    end
  end

  // Handshake and interrupt monitors.
  always @(posedge ap_clk) begin
    if (k_ap_start && k_ap_ready) hs_mon = hs_mon + 1;
  end
  always @(negedge ap_clk) begin
    if (irq_done) irq_cnt = irq_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic send_cfg(input logic [W_DIM-1:0] w, input logic [W_DIM-1:0] h,
                          input logic [7:0] t, input logic [W_CNT-1:0] n);
    @(negedge ap_clk);
    cfg_width = w; cfg_height = h; cfg_threshold = t; cfg_num_frames = n;
    cfg_valid = 1'b1;
    @(negedge ap_clk);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k = 0;
    while (busy && k < budget) begin
      @(negedge ap_clk);
      k++;
    end
    check(name, 32'(busy), 0);
  endtask

  typedef struct {
    logic [W_DIM-1:0] w;
    logic [W_DIM-1:0] h;
    logic [7:0]       thr;
    logic             acc;
    logic             ecfg;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int base_hs, base_irq, k;

    vecs[0] = '{w: 12'd64,   h: 12'd48,   thr: 8'd20,  acc: 1'b1, ecfg: 1'b0};
    vecs[1] = '{w: 12'd6,    h: 12'd48,   thr: 8'd20,  acc: 1'b0, ecfg: 1'b1};
    vecs[2] = '{w: 12'd7,    h: 12'd7,    thr: 8'd3,   acc: 1'b1, ecfg: 1'b1};
    vecs[3] = '{w: 12'd64,   h: 12'd6,    thr: 8'd9,   acc: 1'b0, ecfg: 1'b1};
    vecs[4] = '{w: 12'd4095, h: 12'd4095, thr: 8'd255, acc: 1'b1, ecfg: 1'b1};
    vecs[5] = '{w: 12'd0,    h: 12'd0,    thr: 8'd1,   acc: 1'b0, ecfg: 1'b1};

    ap_rst_n = 1'b0;
    cfg_valid = 1'b0; cfg_width = '0; cfg_height = '0; cfg_threshold = '0; cfg_num_frames = '0;
    ctrl_abort = 1'b0; ctrl_clear = 1'b0; src_blk = 1'b0; dst_blk = 1'b0;
    auto_kernel = 1'b0; h_ready = 1'b0; h_done = 1'b0; h_idle = 1'b1;

    repeat (3) @(negedge ap_clk);
    check("rst k_ap_start", 32'(k_ap_start), 0);
    check("rst busy", 32'(busy), 0);
    check("rst cfg_ready", 32'(cfg_ready), 0);
    check("rst irq_done", 32'(irq_done), 0);
    check("rst err_cfg", 32'(err_cfg), 0);
    check("rst err_stall", 32'(err_stall), 0);
    check("rst frames_done", 32'(frames_done), 0);
    check("rst k_width", 32'(k_width), 0);
    check("rst k_threshold", 32'(k_threshold), 0);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    check("post-rst busy", 32'(busy), 0);

    // Config table: accepted entries complete one frame via ready+done in the START cycle.
    for (int i = 0; i < 6; i++) begin
      @(negedge ap_clk);
      cfg_width = vecs[i].w; cfg_height = vecs[i].h; cfg_threshold = vecs[i].thr;
      cfg_num_frames = 16'd1; cfg_valid = 1'b1;
      #1;
      check($sformatf("v%0d cfg_ready", i), 32'(cfg_ready), 1);
      @(negedge ap_clk);
      cfg_valid = 1'b0;
      check($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].acc));
      check($sformatf("v%0d k_ap_start", i), 32'(k_ap_start), 32'(vecs[i].acc));
      check($sformatf("v%0d err_cfg", i), 32'(err_cfg), 32'(vecs[i].ecfg));
      if (vecs[i].acc) begin
        check($sformatf("v%0d k_width", i), 32'(k_width), 32'(vecs[i].w));
        check($sformatf("v%0d k_height", i), 32'(k_height), 32'(vecs[i].h));
        check($sformatf("v%0d k_threshold", i), 32'(k_threshold), 32'(vecs[i].thr));
        check($sformatf("v%0d frames_done clr", i), 32'(frames_done), 0);
        h_ready = 1'b1; h_done = 1'b1;
        @(negedge ap_clk);
        h_ready = 1'b0; h_done = 1'b0;
        check($sformatf("v%0d irq_done", i), 32'(irq_done), 1);
        check($sformatf("v%0d frames_done", i), 32'(frames_done), 1);
        check($sformatf("v%0d start dropped", i), 32'(k_ap_start), 0);
        @(negedge ap_clk);
        check($sformatf("v%0d idle", i), 32'(busy), 0);
        check($sformatf("v%0d irq single", i), 32'(irq_done), 0);
      end else begin
        @(negedge ap_clk);
        check($sformatf("v%0d stays idle", i), 32'(busy), 0);
        check($sformatf("v%0d no start", i), 32'(k_ap_start), 0);
      end
    end

    // Abort and done in the same RUN cycle ends a continuous run on that frame.
    send_cfg(12'd32, 12'd32, 8'd10, 16'd0);
    h_ready = 1'b1;
    @(negedge ap_clk);
    h_ready = 1'b0;
    repeat (3) @(negedge ap_clk);
    check("abort+done in run", 32'(busy), 1);
    ctrl_abort = 1'b1; h_done = 1'b1;
    @(negedge ap_clk);
    ctrl_abort = 1'b0; h_done = 1'b0;
    check("abort+done irq", 32'(irq_done), 1);
    check("abort+done frames", 32'(frames_done), 1);
    @(negedge ap_clk);
    check("abort+done idle", 32'(busy), 0);

    // Three-frame run against the kernel model.
    base_hs = hs_mon; base_irq = irq_cnt;
    auto_kernel = 1'b1;
    send_cfg(12'd64, 12'd48, 8'd20, 16'd3);
    wait_idle(1000, "run3 timeout");
    check("run3 handshakes", 32'(hs_mon - base_hs), 3);
    check("run3 frames_done", 32'(frames_done), 3);
    check("run3 irq pulses", 32'(irq_cnt - base_irq), 1);
    auto_kernel = 1'b0;
    repeat (2) @(negedge ap_clk);

    // Continuous run aborted during frame 5.
    base_hs = hs_mon; base_irq = irq_cnt;
    auto_kernel = 1'b1;
    send_cfg(12'd64, 12'd48, 8'd20, 16'd0);
    k = 0;
    while ((hs_mon - base_hs) < 5 && k < 2000) begin
      @(negedge ap_clk);
      k++;
    end
    check("cont reach frame5", 32'(hs_mon - base_hs), 5);
    repeat (10) @(negedge ap_clk);
    ctrl_abort = 1'b1;
    repeat (2) @(negedge ap_clk);
    ctrl_abort = 1'b0;
    wait_idle(500, "cont timeout");
    check("cont frames_done", 32'(frames_done), 5);
    check("cont handshakes", 32'(hs_mon - base_hs), 5);
    check("cont irq pulses", 32'(irq_cnt - base_irq), 1);
    auto_kernel = 1'b0;
    repeat (2) @(negedge ap_clk);

    // Watchdog: 15 stalled cycles survive, the 16th expires.
    send_cfg(12'd64, 12'd48, 8'd20, 16'd0);
    h_ready = 1'b1;
    @(negedge ap_clk);
    h_ready = 1'b0;
    src_blk = 1'b1;
    repeat (15) @(negedge ap_clk);
    src_blk = 1'b0;
    check("wdog 15 no err", 32'(err_stall), 0);
    check("wdog 15 busy", 32'(busy), 1);
    @(negedge ap_clk);
    src_blk = 1'b1;
    repeat (15) @(negedge ap_clk);
    check("wdog pre-expiry", 32'(err_stall), 0);
    @(negedge ap_clk);
    src_blk = 1'b0;
    check("wdog 16 err_stall", 32'(err_stall), 1);
    check("wdog err k_ap_start", 32'(k_ap_start), 0);
    check("wdog err busy", 32'(busy), 1);
    h_idle = 1'b0; ctrl_clear = 1'b1;
    @(negedge ap_clk);
    ctrl_clear = 1'b0;
    check("clear non-idle err_stall", 32'(err_stall), 1);
    check("clear non-idle busy", 32'(busy), 1);
    h_idle = 1'b1; ctrl_clear = 1'b1;
    @(negedge ap_clk);
    ctrl_clear = 1'b0;
    check("clear idle busy", 32'(busy), 0);
    check("clear idle err_stall", 32'(err_stall), 0);
    check("clear idle err_cfg", 32'(err_cfg), 0);

    // Asynchronous reset while a start is pending.
    send_cfg(12'd100, 12'd50, 8'd7, 16'd1);
    check("pre-rst k_ap_start", 32'(k_ap_start), 1);
    #2 ap_rst_n = 1'b0;
    #1;
    check("arst k_ap_start", 32'(k_ap_start), 0);
    check("arst busy", 32'(busy), 0);
    check("arst k_width", 32'(k_width), 0);
    check("arst k_threshold", 32'(k_threshold), 0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    repeat (5) @(negedge ap_clk);
    check("after arst idle", 32'(busy), 0);
    check("after arst no start", 32'(k_ap_start), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
